// File: rtl/t16_mem_system.sv
// ---------------------------------------------------------------------------
// t16_mem_system
//
// Memory-side responder for the T16 single-cycle core.
//
// This block holds the core's program counter. It serves instructions from a
// 32-word instruction RAM and serves the core's data port from a data RAM.
// Before the core may run, a word-wide load interface fills the instruction
// RAM.
//
// Optional feature macro: T16_MEMIO_EN
//   When this macro is defined, address 16'hFFFF becomes a memory-mapped
//   output register:
//     - writes to 16'hFFFF drive the extra io_out port;
//     - reads of 16'hFFFF return the current io_out value.
//   When it is undefined, 16'hFFFF is an ordinary out-of-range address.
//
// Parameters
//   DDEPTH     data RAM depth in 16-bit words (power of two, 2..65536)
//   NOP_INSTR  instruction word presented on instr while not running
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   cpc / instr      current PC and the instruction at imem[cpc]
//   nxtpc            next PC from the core, taken every RUN cycle
//   memwrite, writeaddr, writedata   data write port
//   readaddr / readdata              combinational data read port
//   ld_start, ld_valid, ld_ready, ld_data, ld_last   program load channel
//   running          high while the core is allowed to execute
//   io_out           (T16_MEMIO_EN only) memory-mapped output register
// ---------------------------------------------------------------------------
module t16_mem_system #(
   parameter int unsigned DDEPTH    = 32,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [4:0]  cpc,
   output logic [15:0] instr,
   input  logic [4:0]  nxtpc,
   input  logic        memwrite,
   input  logic [15:0] writeaddr,
   input  logic [15:0] writedata,
   input  logic [15:0] readaddr,
   output logic [15:0] readdata,
   input  logic        ld_start,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [15:0] ld_data,
   input  logic        ld_last,
   output logic        running
`ifdef T16_MEMIO_EN
   ,
   output logic [15:0] io_out
`endif
);

   localparam int unsigned AW        = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
   // The depth is widened to 17 bits so that DDEPTH=65536 can still be compared.
   localparam logic [16:0] DEPTH_LIM = 17'(DDEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  ld_ptr_q, ld_ptr_d;
   logic [4:0]  cpc_q, cpc_d;
   logic        imem_we;
   logic        dmem_we;
   logic        wr_in_range;
   logic        rd_in_range;

   logic [15:0] imem_q [32];
   logic [15:0] dmem_q [DDEPTH];

`ifdef T16_MEMIO_EN
   logic [15:0] io_out_q, io_out_d;
   logic        wr_is_io;
   logic        rd_is_io;
`endif

   // Address decoding for the data port. An address is in range only when it
   // falls below DDEPTH. The I/O address takes precedence over the RAM when
   // the optional register exists, which only matters when DDEPTH=65536.
   always_comb begin
      wr_in_range = ({1'b0, writeaddr} < DEPTH_LIM);
      rd_in_range = ({1'b0, readaddr} < DEPTH_LIM);
`ifdef T16_MEMIO_EN
      wr_is_io    = (writeaddr == 16'hFFFF);
      rd_is_io    = (readaddr == 16'hFFFF);
`endif
   end

   // Load/run sequencing.
   //
   // Every output is given a default value first. After that, each state
   // overrides only what it owns.
   //
   // In LOAD, a restart wins over a beat in the same cycle, and that beat is
   // discarded. The load pointer saturates at 31, so that a full 32-word load
   // cannot wrap. Outside RUN the PC is forced to 0. Because of this, the core
   // always begins executing at imem[0].
   always_comb begin
      state_d  = state_q;
      ld_ptr_d = ld_ptr_q;
      cpc_d    = 5'd0;
      imem_we  = 1'b0;
      ld_ready = 1'b0;
      running  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               state_d  = ST_LOAD;
               ld_ptr_d = 5'd0;
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_start) begin
               ld_ptr_d = 5'd0;
            end else if (ld_valid) begin
               imem_we = 1'b1;
               if (ld_ptr_q != 5'd31) begin
                  ld_ptr_d = ld_ptr_q + 5'd1;
               end
               if (ld_last || (ld_ptr_q == 5'd31)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            running = 1'b1;
            cpc_d   = nxtpc;
            if (ld_start) begin
               state_d  = ST_LOAD;
               cpc_d    = 5'd0;
               ld_ptr_d = 5'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Data-side write enables.
   //
   // The core may only modify memory while it is running. When the optional
   // I/O register is present, a write to its address is redirected away from
   // the data RAM and into that register.
   always_comb begin
`ifdef T16_MEMIO_EN
      dmem_we  = running && memwrite && wr_in_range && !wr_is_io;
      io_out_d = io_out_q;
      if (running && memwrite && wr_is_io) begin
         io_out_d = writedata;
      end
`else
      dmem_we  = running && memwrite && wr_in_range;
`endif
   end

   // Control state registers. These use a synchronous active-low reset. The
   // RAM arrays are deliberately kept out of this block, so that a reset
   // leaves the loaded program in place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ld_ptr_q <= 5'd0;
         cpc_q    <= 5'd0;
`ifdef T16_MEMIO_EN
         io_out_q <= 16'h0000;
`endif
      end else begin
         state_q  <= state_d;
         ld_ptr_q <= ld_ptr_d;
         cpc_q    <= cpc_d;
`ifdef T16_MEMIO_EN
         io_out_q <= io_out_d;
`endif
      end
   end

   // Instruction and data RAM write ports. These arrays are not reset. Writes
   // are suppressed while reset is asserted, so that a reset issued in the
   // middle of a load cannot store a stray beat.
   always_ff @(posedge clk) begin
      if (rst_n && imem_we) begin
         imem_q[ld_ptr_q] <= ld_data;
      end
      if (rst_n && dmem_we) begin
         dmem_q[writeaddr[AW-1:0]] <= writedata;
      end
   end

   // Combinational read paths.
   //
   // The single-cycle core needs the instruction and the load data in the
   // same cycle it presents the address. A write in the current cycle only
   // lands at the clock edge. Because of this, a same-address read sees the
   // old value.
   always_comb begin
      cpc      = cpc_q;
      instr    = running ? imem_q[cpc_q] : NOP_INSTR;
      readdata = 16'h0000;
`ifdef T16_MEMIO_EN
      io_out   = io_out_q;
      if (rd_is_io) begin
         readdata = io_out_q;
      end else if (rd_in_range) begin
         readdata = dmem_q[readaddr[AW-1:0]];
      end
`else
      if (rd_in_range) begin
         readdata = dmem_q[readaddr[AW-1:0]];
      end
`endif
   end

endmodule
